// File: rtl/stavka_c.sv
// stavka_c: 4-bit registered shifter/doubler with an operation counter.
// One opcode per clock; data_out is fully registered.
module stavka_c #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       control,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_DBL  = 3'b110,
        OP_RDC  = 3'b111
    } op_t;

    op_t                  op;
    logic [WIDTH-1:0]     r;
    logic [WIDTH-1:0]     r_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 cnt_inc;
    logic [WIDTH-1:0]     cnt_ext;

    assign op      = op_t'(control);
    assign cnt_ext = WIDTH'(cnt);

    always_comb begin
        r_next  = r;
        cnt_inc = 1'b1;
        unique case (op)
            OP_NOP:  cnt_inc = 1'b0;
            OP_LOAD: r_next = data_in;
            OP_SHL:  r_next = {r[WIDTH-2:0], 1'b0};
            OP_SHR:  r_next = {1'b0, r[WIDTH-1:1]};
            OP_ROL:  r_next = {r[WIDTH-2:0], r[WIDTH-1]};
            OP_ROR:  r_next = {r[0], r[WIDTH-1:1]};
            OP_DBL:  r_next = {data_in[WIDTH-2:0], 1'b0};
            OP_RDC:  cnt_inc = 1'b0;
            default: cnt_inc = 1'b0;
        endcase
    end

    // rst_n is active-high here; the name is historical
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r        <= '0;
            cnt      <= '0;
            data_out <= '0;
        end else begin
            r        <= r_next;
            cnt      <= cnt + CNT_WIDTH'(cnt_inc);
            data_out <= (op == OP_RDC) ? cnt_ext : r_next;
        end
    end

endmodule

// File: tb/tb_stavka_c.sv
// tb_stavka_c: directed vectors for stavka_c.
// Expected values are hand-computed; sampled 1ns after each rising edge.
module tb_stavka_c;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] data_in = '0;
    logic [2:0] control = '0;
    logic [3:0] data_out;

    int vectors = 0;
    int miscompares = 0;

    stavka_c #(.WIDTH(4), .CNT_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .control  (control),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, SHL = 3'b010,
                           SHR = 3'b011, ROL = 3'b100, ROR = 3'b101,
                           DBL = 3'b110, RDC = 3'b111;

    task automatic step(input logic rst, input logic [2:0] c,
                        input logic [3:0] d, input logic [3:0] exp,
                        input string tag);
        rst_n   = rst;
        control = c;
        data_in = d;
        @(posedge clk);
        #1;
        vectors++;
        assert (data_out === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, data_out, exp);
        end
    endtask

    initial begin
        // reset overrides LOAD
        step(1'b1, LOAD, 4'b1010, 4'b0000, "rst_edge1");
        step(1'b1, LOAD, 4'b1010, 4'b0000, "rst_edge2");
        step(1'b0, RDC,  4'b0000, 4'b0000, "rst_cnt");

        step(1'b0, LOAD, 4'b1011, 4'b1011, "load_1011");
        step(1'b0, SHL,  4'b0000, 4'b0110, "shl");
        step(1'b0, SHR,  4'b0000, 4'b0011, "shr");
        step(1'b0, NOP,  4'b0000, 4'b0011, "nop_hold");

        step(1'b0, LOAD, 4'b1001, 4'b1001, "load_1001");
        step(1'b0, ROL,  4'b0000, 4'b0011, "rol");
        step(1'b0, ROR,  4'b0000, 4'b1001, "ror1");
        step(1'b0, ROR,  4'b0000, 4'b1100, "ror2");

        step(1'b0, DBL,  4'b0111, 4'b1110, "dbl_0111");
        step(1'b0, DBL,  4'b1000, 4'b0000, "dbl_1000");

        // 9 counted ops since reset
        step(1'b0, RDC,  4'b0000, 4'b1001, "cnt_9");
        step(1'b0, NOP,  4'b0000, 4'b0000, "after_rdc");

        // counter wrap: LOAD + 14 ROL, peek, 2 ROL, 3 NOP
        step(1'b1, NOP,  4'b0000, 4'b0000, "rst2");
        step(1'b0, LOAD, 4'b0101, 4'b0101, "wrap_load");
        for (int i = 0; i < 14; i++)
            step(1'b0, ROL, 4'b0000,
                 (i % 2 == 0) ? 4'b1010 : 4'b0101, "wrap_rol");
        step(1'b0, RDC,  4'b0000, 4'b1111, "cnt_15");
        step(1'b0, ROL,  4'b0000, 4'b1010, "wrap_rol16");
        step(1'b0, ROL,  4'b0000, 4'b0101, "wrap_rol17");
        for (int i = 0; i < 3; i++)
            step(1'b0, NOP, 4'b1111, 4'b0101, "wrap_nop");
        step(1'b0, RDC,  4'b0000, 4'b0001, "cnt_wrap");
        step(1'b0, NOP,  4'b0000, 4'b0101, "wrap_after_rdc");

        // reset mid-stream overrides SHL
        step(1'b0, LOAD, 4'b1111, 4'b1111, "load_1111");
        step(1'b1, SHL,  4'b0000, 4'b0000, "rst_mid");
        step(1'b0, RDC,  4'b0000, 4'b0000, "rst_mid_cnt");
        step(1'b0, NOP,  4'b0000, 4'b0000, "rst_mid_r");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
